// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Issue side of the ALU interface. Each accepted request latches two operands,
// drives one one-hot ALU strobe for a fixed number of cycles, and then captures
// the ALU result (Chigh/Clow) into the Z registers. After the capture it pulses
// done for one cycle. MUL and DIV use LONG_LAT; every other legal opcode uses
// SHORT_LAT. An unmapped opcode never strobes the ALU. It completes right away
// with done and illegal both high.
//
// Ports
//   clock      : system clock, all state on the rising edge
//   clear      : synchronous active-high reset, priority over every other input
//   start      : request, sampled only while idle
//   opcode     : 5-bit CPU opcode, sampled with start
//   ra_data    : operand A, sampled with start
//   rb_data    : operand B, sampled with start
//   alu_chigh  : ALU high result
//   alu_clow   : ALU low result
//   alu_a      : latched operand A driven to the ALU
//   alu_b      : latched operand B driven to the ALU
//   op_sel     : one-hot ALU strobes, 13..0 =
//                IncPC,NOT,NEG,ROL,ROR,SHL,SHRA,SHR,OR,AND,DIV,MUL,SUB,ADD
//   z_high     : captured high result (updated only by MUL/DIV)
//   z_low      : captured low result
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   illegal    : high together with done when the opcode was unmapped
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int SHORT_LAT = 1,
  parameter int LONG_LAT  = 32
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] ra_data,
  input  logic [31:0] rb_data,
  input  logic [31:0] alu_chigh,
  input  logic [31:0] alu_clow,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [13:0] op_sel,
  output logic [31:0] z_high,
  output logic [31:0] z_low,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  // The counter is loaded with LAT-1 and counts down to zero. Its largest
  // value is therefore MAX_LAT-1.
  localparam int MAX_LAT = (SHORT_LAT > LONG_LAT) ? SHORT_LAT : LONG_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_LAT - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_LAT - 1);

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // CPU opcode map
  localparam logic [4:0] OPC_ADD   = 5'b00011;
  localparam logic [4:0] OPC_SUB   = 5'b00100;
  localparam logic [4:0] OPC_SHR   = 5'b00101;
  localparam logic [4:0] OPC_SHRA  = 5'b00110;
  localparam logic [4:0] OPC_SHL   = 5'b00111;
  localparam logic [4:0] OPC_ROR   = 5'b01000;
  localparam logic [4:0] OPC_ROL   = 5'b01001;
  localparam logic [4:0] OPC_AND   = 5'b01010;
  localparam logic [4:0] OPC_OR    = 5'b01011;
  localparam logic [4:0] OPC_MUL   = 5'b01111;
  localparam logic [4:0] OPC_DIV   = 5'b10000;
  localparam logic [4:0] OPC_NEG   = 5'b10001;
  localparam logic [4:0] OPC_NOT   = 5'b10010;
  localparam logic [4:0] OPC_INCPC = 5'b11111;

  // Bit positions inside op_sel
  localparam int B_ADD   = 0;
  localparam int B_SUB   = 1;
  localparam int B_MUL   = 2;
  localparam int B_DIV   = 3;
  localparam int B_AND   = 4;
  localparam int B_OR    = 5;
  localparam int B_SHR   = 6;
  localparam int B_SHRA  = 7;
  localparam int B_SHL   = 8;
  localparam int B_ROR   = 9;
  localparam int B_ROL   = 10;
  localparam int B_NEG   = 11;
  localparam int B_NOT   = 12;
  localparam int B_INCPC = 13;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q;
  logic [13:0]      decoded;
  logic             decoded_long;

  // Map an opcode to its one-hot strobe. An all-zero result marks the
  // opcode as unmapped.
  function automatic logic [13:0] decode_op(input logic [4:0] op);
    logic [13:0] sel;
    // NOTE: sel gets a default before the case, so every path assigns it.
    // Without this default, combinational use of the function would infer a latch.
    sel = '0;
    case (op)
      OPC_ADD:   sel[B_ADD]   = 1'b1;
      OPC_SUB:   sel[B_SUB]   = 1'b1;
      OPC_SHR:   sel[B_SHR]   = 1'b1;
      OPC_SHRA:  sel[B_SHRA]  = 1'b1;
      OPC_SHL:   sel[B_SHL]   = 1'b1;
      OPC_ROR:   sel[B_ROR]   = 1'b1;
      OPC_ROL:   sel[B_ROL]   = 1'b1;
      OPC_AND:   sel[B_AND]   = 1'b1;
      OPC_OR:    sel[B_OR]    = 1'b1;
      OPC_MUL:   sel[B_MUL]   = 1'b1;
      OPC_DIV:   sel[B_DIV]   = 1'b1;
      OPC_NEG:   sel[B_NEG]   = 1'b1;
      OPC_NOT:   sel[B_NOT]   = 1'b1;
      OPC_INCPC: sel[B_INCPC] = 1'b1;
      default:   sel          = '0;
    endcase
    return sel;
  endfunction

  always_comb begin
    decoded      = decode_op(opcode);
    decoded_long = decoded[B_MUL] | decoded[B_DIV];
  end

  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples pre-edge values. This keeps evaluation order irrelevant.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      op_sel    <= '0;
      z_high    <= '0;
      z_low     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (decoded != '0) begin
              alu_a  <= ra_data;
              alu_b  <= rb_data;
              op_sel <= decoded;
              cnt    <= decoded_long ? LONG_LOAD : SHORT_LOAD;
              state  <= ST_EXEC;
            end else begin
              // An unmapped opcode skips the ALU. The operands and the
              // Z registers keep their values.
              illegal_q <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end

        ST_EXEC: begin
          if (cnt == '0) begin
            // This edge ends the last strobe cycle. Only MUL/DIV produce
            // a meaningful Chigh, so z_high is kept for every other op.
            z_low <= alu_clow;
            if (op_sel[B_MUL] | op_sel[B_DIV]) begin
              z_high <= alu_chigh;
            end
            op_sel <= '0;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_DONE: begin
          illegal_q <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          op_sel    <= '0;
          illegal_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from registered state, so they cannot glitch
  // on input changes.
  always_comb begin
    busy    = (state != ST_IDLE);
    done    = (state == ST_DONE);
    illegal = illegal_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer with default parameters
// (SHORT_LAT=1, LONG_LAT=32). Inputs are driven on the falling edge and
// outputs are sampled on the falling edge. The ALU result inputs are
// driven by each test. Wrong values are applied before the final strobe
// cycle, so an early capture is visible.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic [31:0] alu_chigh;
  logic [31:0] alu_clow;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [13:0] op_sel;
  logic [31:0] z_high;
  logic [31:0] z_low;
  logic        busy;
  logic        done;
  logic        illegal;

  int checks;
  int failures;

  alu_op_sequencer #(
    .SHORT_LAT(1),
    .LONG_LAT (32)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .opcode   (opcode),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .alu_chigh(alu_chigh),
    .alu_clow (alu_clow),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .op_sel   (op_sel),
    .z_high   (z_high),
    .z_low    (z_low),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    clear     = 1'b1;
    start     = 1'b0;
    opcode    = 5'b0;
    ra_data   = '0;
    rb_data   = '0;
    alu_chigh = '0;
    alu_clow  = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({alu_a, alu_b, op_sel, z_high, z_low, busy, done, illegal} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h zh=%h zl=%h busy=%b done=%b ill=%b, want all zero",
               alu_a, alu_b, op_sel, z_high, z_low, busy, done, illegal);
    end
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_mul();
    opcode    = 5'b01111;
    ra_data   = 32'h1234;
    rb_data   = 32'h5678;
    alu_chigh = 32'hdead_beef;
    alu_clow  = 32'hcafe_f00d;
    start     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (op_sel !== 14'h0004) begin
        failures++;
        $display("FAIL mid_mul_strobe cycle %0d: got %h want 0004", i, op_sel);
      end
      if (i == 10) clear = 1'b1;
    end
    @(negedge clock);
    clear = 1'b0;
    checks++;
    if ({alu_a, alu_b, op_sel, z_high, z_low, busy, done, illegal} !== '0) begin
      failures++;
      $display("FAIL mid_mul_clear: got a=%h b=%h op=%h zh=%h zl=%h busy=%b done=%b ill=%b, want all zero",
               alu_a, alu_b, op_sel, z_high, z_low, busy, done, illegal);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_mul_no_done: got done=%b busy=%b want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_add();
    opcode    = 5'b00011;
    ra_data   = 32'd5;
    rb_data   = 32'd7;
    alu_chigh = 32'hffff_ffff;
    alu_clow  = 32'd12;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (op_sel !== 14'h0001 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL add_exec: got op=%h busy=%b done=%b want 0001 1 0", op_sel, busy, done);
    end
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
      failures++;
      $display("FAIL add_operands: got a=%0d b=%0d want 5 7", alu_a, alu_b);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || illegal !== 1'b0 || op_sel !== 14'h0) begin
      failures++;
      $display("FAIL add_done: got done=%b ill=%b op=%h want 1 0 0000", done, illegal, op_sel);
    end
    checks++;
    if (z_low !== 32'd12 || z_high !== 32'd0) begin
      failures++;
      $display("FAIL add_result: got zh=%h zl=%h want 0 c", z_high, z_low);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL add_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_illegal();
    opcode    = 5'b00001;
    ra_data   = 32'h99;
    rb_data   = 32'h98;
    alu_clow  = 32'h4444;
    alu_chigh = 32'h3333;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || illegal !== 1'b1 || op_sel !== 14'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL illegal_done: got done=%b ill=%b op=%h busy=%b want 1 1 0000 1",
               done, illegal, op_sel, busy);
    end
    checks++;
    if (z_low !== 32'd12 || z_high !== 32'd0) begin
      failures++;
      $display("FAIL illegal_z_kept: got zh=%h zl=%h want 0 c", z_high, z_low);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear: got done=%b ill=%b busy=%b want 0 0 0", done, illegal, busy);
    end
  endtask

  task automatic test_mul();
    int busy_cycles;
    busy_cycles = 0;
    opcode    = 5'b01111;
    ra_data   = 32'd3;
    rb_data   = 32'd4;
    alu_chigh = 32'haaaa_aaaa;
    alu_clow  = 32'h5555_5555;
    start     = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (op_sel !== 14'h0004 || done !== 1'b0) begin
        failures++;
        $display("FAIL mul_strobe cycle %0d: got op=%h done=%b want 0004 0", i, op_sel, done);
      end
      if (i == 32) begin
        checks++;
        if (z_low !== 32'd12 || z_high !== 32'd0) begin
          failures++;
          $display("FAIL mul_precapture: got zh=%h zl=%h want 0 c", z_high, z_low);
        end
        alu_chigh = 32'h1;
        alu_clow  = 32'h2;
      end
    end
    @(negedge clock);
    if (busy === 1'b1) busy_cycles++;
    checks++;
    if (done !== 1'b1 || op_sel !== 14'h0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL mul_done: got done=%b op=%h ill=%b want 1 0000 0", done, op_sel, illegal);
    end
    checks++;
    if (z_high !== 32'h1 || z_low !== 32'h2) begin
      failures++;
      $display("FAIL mul_result: got zh=%h zl=%h want 1 2", z_high, z_low);
    end
    for (int i = 0; i < 5 && busy === 1'b1; i++) begin
      @(negedge clock);
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles !== 33) begin
      failures++;
      $display("FAIL mul_busy_len: got %0d want 33", busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    int done_count;
    done_count = 0;
    opcode    = 5'b10000;
    ra_data   = 32'h1111;
    rb_data   = 32'h2222;
    alu_chigh = 32'h77;
    alu_clow  = 32'h66;
    start     = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      if (done === 1'b1) done_count++;
      checks++;
      if (op_sel !== 14'h0008 || alu_a !== 32'h1111 || alu_b !== 32'h2222) begin
        failures++;
        $display("FAIL div_hold cycle %0d: got op=%h a=%h b=%h want 0008 1111 2222",
                 i, op_sel, alu_a, alu_b);
      end
      if (i == 5) begin
        start = 1'b1; opcode = 5'b00011; ra_data = 32'hbad; rb_data = 32'hbad;
      end else if (i >= 30) begin
        start = 1'b1; opcode = 5'b00011; ra_data = 32'd9; rb_data = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clock);
    if (done === 1'b1) done_count++;
    checks++;
    if (z_high !== 32'h77 || z_low !== 32'h66) begin
      failures++;
      $display("FAIL div_result: got zh=%h zl=%h want 77 66", z_high, z_low);
    end
    @(negedge clock);
    if (done === 1'b1) done_count++;
    checks++;
    if (busy !== 1'b0 || op_sel !== 14'h0) begin
      failures++;
      $display("FAIL div_idle_gap: got busy=%b op=%h want 0 0000", busy, op_sel);
    end
    checks++;
    if (done_count !== 1) begin
      failures++;
      $display("FAIL div_single_done: got %0d want 1", done_count);
    end
    alu_clow = 32'd10;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (op_sel !== 14'h0001 || alu_a !== 32'd9 || alu_b !== 32'd1) begin
      failures++;
      $display("FAIL held_start_accept: got op=%h a=%h b=%h want 0001 9 1", op_sel, alu_a, alu_b);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || z_low !== 32'd10 || z_high !== 32'h77) begin
      failures++;
      $display("FAIL held_start_result: got done=%b zl=%h zh=%h want 1 a 77", done, z_low, z_high);
    end
    @(negedge clock);
  endtask

  task automatic test_incpc();
    opcode    = 5'b11111;
    ra_data   = 32'd0;
    rb_data   = 32'd100;
    alu_chigh = 32'h5a5a;
    alu_clow  = 32'd101;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (op_sel !== 14'h2000 || alu_b !== 32'd100) begin
      failures++;
      $display("FAIL incpc_exec: got op=%h b=%0d want 2000 100", op_sel, alu_b);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || illegal !== 1'b0 || z_low !== 32'd101 || z_high !== 32'h77) begin
      failures++;
      $display("FAIL incpc_done: got done=%b ill=%b zl=%0d zh=%h want 1 0 101 77",
               done, illegal, z_low, z_high);
    end
    @(negedge clock);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_reset_mid_mul();
    test_add();
    test_illegal();
    test_mul();
    test_back_to_back();
    test_incpc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
